// File: rtl/mac_forward_engine_pkg.sv
// ============================================================================
// Package : mac_forward_pkg
// Purpose : Shared types and helpers for the MAC forwarding engine: the FSM
//           state encoding, the individual/group address bit, and the
//           group-address and flood-mask helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_forward_pkg;

  // I/G bit of a MAC address: the LSB of the first octet, which sits in [47:40].
  localparam int MAC_IG_BIT = 40;

  // Widest port mask flood_mask() can build; callers take the low PORT_COUNT bits.
  localparam int FLOOD_MAX_PORTS = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SRC_REQ  = 3'd1,
    ST_SRC_WAIT = 3'd2,
    ST_LEARN    = 3'd3,
    ST_DST_REQ  = 3'd4,
    ST_DST_WAIT = 3'd5,
    ST_RESULT   = 3'd6
  } fwd_state_t;

  // Group (multicast or broadcast) address: the I/G bit is set.
  function automatic logic is_group(input logic [47:0] mac);
    return mac[MAC_IG_BIT];
  endfunction

  // Every existing port except the ingress port.
  function automatic logic [FLOOD_MAX_PORTS-1:0] flood_mask(input int port, input int count);
    logic [FLOOD_MAX_PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < FLOOD_MAX_PORTS; i++) begin
      if (i < count && i != port) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_forward_engine_if.sv
// ============================================================================
// Interface: mac_forward_engine_if
// Purpose  : Groups the header, CAM and forwarding-decision signals of the
//            MAC forwarding engine. The master modport is the engine's view:
//            it drives the CAM and the decision. The slave modport is the
//            view of its surroundings: the parser, the CAM and the fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_forward_engine_if #(
  parameter int MAC_WIDTH  = 48,
  parameter int PORT_COUNT = 8
);
  localparam int PW = $clog2(PORT_COUNT);

  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [MAC_WIDTH-1:0]  hdr_dst_mac;
  logic [MAC_WIDTH-1:0]  hdr_src_mac;
  logic [PW-1:0]         hdr_ingress_port;

  logic                  cam_write_enable;
  logic                  cam_match_enable;
  logic [MAC_WIDTH-1:0]  cam_key;
  logic [PW-1:0]         cam_index;
  logic [PW-1:0]         cam_match_index;
  logic                  cam_match_valid;
  logic                  cam_no_match;

  logic                  fwd_valid;
  logic                  fwd_ready;
  logic [PORT_COUNT-1:0] fwd_port_mask;
  logic                  fwd_flood;
  logic                  table_full;

  modport master (
    input  hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_ingress_port,
    output hdr_ready,
    output cam_write_enable, cam_match_enable, cam_key, cam_index,
    input  cam_match_index, cam_match_valid, cam_no_match,
    output fwd_valid, fwd_port_mask, fwd_flood, table_full,
    input  fwd_ready
  );

  modport slave (
    output hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_ingress_port,
    input  hdr_ready,
    input  cam_write_enable, cam_match_enable, cam_key, cam_index,
    output cam_match_index, cam_match_valid, cam_no_match,
    input  fwd_valid, fwd_port_mask, fwd_flood, table_full,
    output fwd_ready
  );

endinterface

`default_nettype wire

// File: rtl/mac_forward_engine_stats.sv
// ============================================================================
// Module  : mac_forward_stats
// Purpose : Free-running 32-bit event counters for the forwarding engine:
//           frames forwarded, addresses learned, floods and filtered frames.
//           The counters wrap and are cleared by reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_forward_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire_i,
  input  logic        learn_i,
  input  logic        flood_i,
  input  logic        filtered_i,
  output logic [31:0] frames_o,
  output logic [31:0] learns_o,
  output logic [31:0] floods_o,
  output logic [31:0] filtered_o
);

  logic [31:0] frames_q, learns_q, floods_q, filtered_q;

  // Frame, flood and filter counts advance on the decision handshake; learns advance on each learn cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q   <= '0;
      learns_q   <= '0;
      floods_q   <= '0;
      filtered_q <= '0;
    end else begin
      if (learn_i) learns_q <= learns_q + 32'd1;
      if (fire_i) begin
        frames_q <= frames_q + 32'd1;
        if (flood_i)    floods_q   <= floods_q + 32'd1;
        if (filtered_i) filtered_q <= filtered_q + 32'd1;
      end
    end
  end

  assign frames_o   = frames_q;
  assign learns_o   = learns_q;
  assign floods_o   = floods_q;
  assign filtered_o = filtered_q;

endmodule

`default_nettype wire

// File: rtl/mac_forward_engine.sv
// ============================================================================
// Module  : mac_forward_engine
// Purpose : Accepts one parsed frame header at a time, looks up the source
//           MAC in the CAM, learns the source when it is unknown, looks up the
//           destination MAC, and presents an egress port mask to the fabric.
//           Group and all-zero destinations flood without a lookup.
//           Define MAC_FWD_STATS_EN to add the stat_* counter outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_forward_engine
  import mac_forward_pkg::*;
#(
  parameter int MAC_WIDTH   = 48,
  parameter int PORT_COUNT  = 8,
  parameter int TABLE_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  mac_forward_engine_if.master bus
`ifdef MAC_FWD_STATS_EN
  ,
  output logic [31:0]         stat_frames_o,
  output logic [31:0]         stat_learns_o,
  output logic [31:0]         stat_floods_o,
  output logic [31:0]         stat_filtered_o
`endif
);

  localparam int PW  = $clog2(PORT_COUNT);
  localparam int LCW = $clog2(TABLE_DEPTH + 1);
  localparam logic [LCW-1:0] LC_MAX = LCW'(TABLE_DEPTH);

  fwd_state_t            state_q;
  logic [MAC_WIDTH-1:0]  dst_q, src_q;
  logic [PW-1:0]         port_q;
  logic [LCW-1:0]        learn_count_q;

  logic                  hdr_ready_q;
  logic                  cam_we_q, cam_me_q;
  logic [MAC_WIDTH-1:0]  cam_key_q;
  logic [PW-1:0]         cam_index_q;
  logic                  fwd_valid_q, fwd_flood_q;
  logic [PORT_COUNT-1:0] fwd_mask_q;

  logic                  w_table_full;
  logic                  w_src_hit;
  logic                  w_dst_hit;
  logic                  w_learn;
  logic                  w_dst_lookup;
  logic [FLOOD_MAX_PORTS-1:0]          w_flood_wide;
  logic [FLOOD_MAX_PORTS-1:PORT_COUNT] w_unused_flood_hi;
  logic [PORT_COUNT-1:0] w_flood;
  logic [PORT_COUNT-1:0] w_hit_mask;

  assign w_table_full = (learn_count_q == LC_MAX);
  // A CAM result with both flags low (or both high) counts as a miss.
  assign w_src_hit    = bus.cam_match_valid && !bus.cam_no_match;
  assign w_dst_hit    = w_src_hit;
  // An all-zero key would alias the CAM's unfilled slots, so it is never learned.
  assign w_learn      = !w_src_hit && !w_table_full && !is_group(src_q) && (src_q != '0);
  assign w_dst_lookup = !is_group(dst_q) && (dst_q != '0);

  assign w_flood_wide      = flood_mask(int'(port_q), PORT_COUNT);
  assign w_flood           = w_flood_wide[PORT_COUNT-1:0];
  assign w_unused_flood_hi = w_flood_wide[FLOOD_MAX_PORTS-1:PORT_COUNT];
  // A destination learned on the ingress port stays local: empty mask.
  assign w_hit_mask = (bus.cam_match_index == port_q) ? '0
                                                      : (PORT_COUNT'(1) << bus.cam_match_index);

  // Frame sequencer: source lookup, optional learn, optional destination lookup, then hold the decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dst_q         <= '0;
      src_q         <= '0;
      port_q        <= '0;
      learn_count_q <= '0;
      hdr_ready_q   <= 1'b0;
      cam_we_q      <= 1'b0;
      cam_me_q      <= 1'b0;
      cam_key_q     <= '0;
      cam_index_q   <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_flood_q   <= 1'b0;
      fwd_mask_q    <= '0;
    end else begin
      cam_we_q <= 1'b0;
      cam_me_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          hdr_ready_q <= 1'b1;
          if (bus.hdr_valid && hdr_ready_q) begin
            dst_q       <= bus.hdr_dst_mac;
            src_q       <= bus.hdr_src_mac;
            port_q      <= bus.hdr_ingress_port;
            hdr_ready_q <= 1'b0;
            cam_me_q    <= 1'b1;
            cam_key_q   <= bus.hdr_src_mac;
            state_q     <= ST_SRC_REQ;
          end
        end
        ST_SRC_REQ: state_q <= ST_SRC_WAIT;
        ST_SRC_WAIT, ST_LEARN: begin
          if (state_q == ST_SRC_WAIT && w_learn) begin
            cam_we_q    <= 1'b1;
            cam_key_q   <= src_q;
            cam_index_q <= port_q;
            if (learn_count_q != LC_MAX) learn_count_q <= learn_count_q + 1'b1;
            state_q     <= ST_LEARN;
          end else if (w_dst_lookup) begin
            cam_me_q  <= 1'b1;
            cam_key_q <= dst_q;
            state_q   <= ST_DST_REQ;
          end else begin
            fwd_valid_q <= 1'b1;
            fwd_mask_q  <= w_flood;
            fwd_flood_q <= 1'b1;
            state_q     <= ST_RESULT;
          end
        end
        ST_DST_REQ: state_q <= ST_DST_WAIT;
        ST_DST_WAIT: begin
          fwd_valid_q <= 1'b1;
          fwd_mask_q  <= w_dst_hit ? w_hit_mask : w_flood;
          fwd_flood_q <= !w_dst_hit;
          state_q     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.fwd_ready) begin
            fwd_valid_q <= 1'b0;
            fwd_mask_q  <= '0;
            fwd_flood_q <= 1'b0;
            hdr_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.hdr_ready        = hdr_ready_q;
  assign bus.cam_write_enable = cam_we_q;
  assign bus.cam_match_enable = cam_me_q;
  assign bus.cam_key          = cam_key_q;
  assign bus.cam_index        = cam_index_q;
  assign bus.fwd_valid        = fwd_valid_q;
  assign bus.fwd_port_mask    = fwd_mask_q;
  assign bus.fwd_flood        = fwd_flood_q;
  assign bus.table_full       = w_table_full;

`ifdef MAC_FWD_STATS_EN
  mac_forward_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .fire_i     (fwd_valid_q && bus.fwd_ready),
    .learn_i    (state_q == ST_LEARN),
    .flood_i    (fwd_flood_q),
    .filtered_i (!fwd_flood_q && (fwd_mask_q == '0)),
    .frames_o   (stat_frames_o),
    .learns_o   (stat_learns_o),
    .floods_o   (stat_floods_o),
    .filtered_o (stat_filtered_o)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_forward_engine.sv
// ============================================================================
// Module  : tb_mac_forward_engine
// Purpose : Pairs the forwarding engine with a behavioural CAM and compares
//           every frame against a table-level model of the learn and
//           forwarding rules.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_forward_engine;

  localparam int TABLE_DEPTH = 32;
  localparam logic [47:0] MAC_0A = 48'h0200_0000_000A;
  localparam logic [47:0] MAC_0B = 48'h0200_0000_000B;
  localparam logic [47:0] MAC_BC = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [7:0]  lat;
    logic [7:0]  mask;
    logic        flood;
    logic [3:0]  nwr;
    logic [47:0] wr_key;
    logic [2:0]  wr_idx;
    logic [3:0]  nmatch;
    logic [47:0] m_key0;
    logic [47:0] m_key1;
    logic        stable;
    logic        vlow;
  } frame_obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_forward_engine_if #(.MAC_WIDTH(48), .PORT_COUNT(8)) bus ();

`ifdef MAC_FWD_STATS_EN
  logic [31:0] stat_frames, stat_learns, stat_floods, stat_filtered;
  int ex_frames = 0, ex_learns = 0, ex_floods = 0, ex_filt = 0;
`endif

  mac_forward_engine #(.MAC_WIDTH(48), .PORT_COUNT(8), .TABLE_DEPTH(TABLE_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAC_FWD_STATS_EN
    ,
    .stat_frames_o   (stat_frames),
    .stat_learns_o   (stat_learns),
    .stat_floods_o   (stat_floods),
    .stat_filtered_o (stat_filtered)
`endif
  );

  // Behavioural CAM: blind append on write, lowest-index match, one-cycle result latency.
  logic [47:0] cam_k [TABLE_DEPTH];
  logic [2:0]  cam_p [TABLE_DEPTH];
  int          cam_n;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_n               <= 0;
      bus.cam_match_valid <= 1'b0;
      bus.cam_no_match    <= 1'b0;
      bus.cam_match_index <= '0;
    end else begin
      bus.cam_match_valid <= 1'b0;
      bus.cam_no_match    <= 1'b0;
      if (bus.cam_write_enable && cam_n < TABLE_DEPTH) begin
        cam_k[cam_n] <= bus.cam_key;
        cam_p[cam_n] <= bus.cam_index;
        cam_n        <= cam_n + 1;
      end
      if (bus.cam_match_enable) begin : srch
        int hit;
        hit = -1;
        for (int i = cam_n - 1; i >= 0; i--) if (cam_k[i] == bus.cam_key) hit = i;
        if (hit >= 0) begin
          bus.cam_match_valid <= 1'b1;
          bus.cam_match_index <= cam_p[hit];
        end else begin
          bus.cam_no_match <= 1'b1;
        end
      end
    end
  end

  // Strobe protocol monitor: never both strobes together, never either strobe two cycles running.
  int   viol = 0;
  logic pwe = 1'b0, pme = 1'b0;
  always @(negedge clk) begin
    if ((bus.cam_write_enable && bus.cam_match_enable) ||
        (bus.cam_write_enable && pwe) || (bus.cam_match_enable && pme))
      viol <= viol + 1;
    pwe <= bus.cam_write_enable;
    pme <= bus.cam_match_enable;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: address -> learned port.
  logic [2:0] mdl_tab [logic [47:0]];

  task automatic model_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [2:0] port, output frame_obs_t e);
    bit learn, lookup;
    e      = '0;
    learn  = !mdl_tab.exists(src) && (mdl_tab.num() < TABLE_DEPTH) && !src[40] && (src != 48'h0);
    if (learn) mdl_tab[src] = port;
    lookup = !dst[40] && (dst != 48'h0);
    e.lat    = 8'((lookup ? 5 : 3) + (learn ? 1 : 0));
    e.nwr    = learn ? 4'd1 : 4'd0;
    e.wr_key = learn ? src : 48'h0;
    e.wr_idx = learn ? port : 3'd0;
    e.nmatch = lookup ? 4'd2 : 4'd1;
    e.m_key0 = src;
    e.m_key1 = lookup ? dst : 48'h0;
    if (lookup && mdl_tab.exists(dst)) begin
      e.flood = 1'b0;
      e.mask  = (mdl_tab[dst] == port) ? 8'h00 : (8'h01 << mdl_tab[dst]);
    end else begin
      e.flood = 1'b1;
      e.mask  = ~(8'h01 << port);
    end
    e.stable = 1'b1;
    e.vlow   = 1'b1;
`ifdef MAC_FWD_STATS_EN
    ex_frames++;
    if (learn) ex_learns++;
    if (e.flood) ex_floods++;
    if (!e.flood && e.mask == 8'h00) ex_filt++;
`endif
  endtask

  // Offers one header, records the CAM traffic and the decision, holds fwd_ready low for 'hold' cycles.
  task automatic run_frame(input logic [47:0] dst, input logic [47:0] src,
                           input logic [2:0] port, input int hold, output frame_obs_t o);
    int k;
    o = '0;
    o.lat = 8'd99;
    k = 0;
    while (!bus.hdr_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.hdr_ready) begin o.lat = 8'd98; return; end
    bus.hdr_valid        = 1'b1;
    bus.hdr_dst_mac      = dst;
    bus.hdr_src_mac      = src;
    bus.hdr_ingress_port = port;
    @(posedge clk);
    @(negedge clk);
    bus.hdr_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.cam_write_enable) begin
        o.nwr    = o.nwr + 4'd1;
        o.wr_key = bus.cam_key;
        o.wr_idx = bus.cam_index;
      end
      if (bus.cam_match_enable) begin
        if (o.nmatch == 4'd0) o.m_key0 = bus.cam_key;
        else                  o.m_key1 = bus.cam_key;
        o.nmatch = o.nmatch + 4'd1;
      end
      if (bus.fwd_valid) begin o.lat = 8'(c); break; end
      @(negedge clk);
    end
    if (o.lat == 8'd99) return;
    o.mask   = bus.fwd_port_mask;
    o.flood  = bus.fwd_flood;
    o.stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (bus.fwd_valid !== 1'b1 || bus.fwd_port_mask !== o.mask || bus.fwd_flood !== o.flood)
        o.stable = 1'b0;
    end
    bus.fwd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.fwd_ready = 1'b0;
    o.vlow = !bus.fwd_valid;
  endtask

  task automatic test_reset;
    logic [72:0] outs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    outs = {bus.hdr_ready, bus.cam_write_enable, bus.cam_match_enable, bus.cam_key, bus.cam_index,
            bus.fwd_valid, bus.fwd_port_mask, bus.fwd_flood, bus.table_full};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs got=%h want=0", outs); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.hdr_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.hdr_ready); else n_pass++;
  endtask

  task automatic test_learn_flood;
    frame_obs_t o, e;
    model_frame(48'h0200_0000_0077, MAC_0A, 3'd3, e);
    run_frame(48'h0200_0000_0077, MAC_0A, 3'd3, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL learn_flood got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.mask !== 8'hF7 || o.flood !== 1'b1 || o.lat !== 8'd6 || o.wr_idx !== 3'd3)
      $display("FAIL learn_flood_fixed got mask=%h flood=%b lat=%0d idx=%0d want F7/1/6/3",
               o.mask, o.flood, o.lat, o.wr_idx);
    else n_pass++;
  endtask

  task automatic test_known_dst;
    frame_obs_t o, e;
    model_frame(MAC_0A, MAC_0B, 3'd5, e);
    run_frame(MAC_0A, MAC_0B, 3'd5, 2, o);
    n_checks++;
    if (o !== e) $display("FAIL known_dst got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.mask !== 8'h08 || o.flood !== 1'b0 || o.wr_key !== MAC_0B)
      $display("FAIL known_dst_fixed got mask=%h flood=%b wkey=%h want 08/0/%h", o.mask, o.flood, o.wr_key, MAC_0B);
    else n_pass++;
  endtask

  task automatic test_broadcast;
    frame_obs_t o, e;
    model_frame(MAC_BC, MAC_0A, 3'd0, e);
    run_frame(MAC_BC, MAC_0A, 3'd0, 1, o);
    n_checks++;
    if (o !== e) $display("FAIL broadcast got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.mask !== 8'hFE || o.lat !== 8'd3 || o.nmatch !== 4'd1 || o.nwr !== 4'd0)
      $display("FAIL broadcast_fixed got mask=%h lat=%0d nmatch=%0d nwr=%0d want FE/3/1/0",
               o.mask, o.lat, o.nmatch, o.nwr);
    else n_pass++;
  endtask

  task automatic test_filter;
    frame_obs_t o, e;
`ifdef MAC_FWD_STATS_EN
    logic [31:0] before;
    before = stat_filtered;
`endif
    model_frame(MAC_0A, MAC_0B, 3'd3, e);
    run_frame(MAC_0A, MAC_0B, 3'd3, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL filter got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.mask !== 8'h00 || o.flood !== 1'b0)
      $display("FAIL filter_fixed got mask=%h flood=%b want 00/0", o.mask, o.flood);
    else n_pass++;
`ifdef MAC_FWD_STATS_EN
    n_checks++;
    if (stat_filtered !== before + 32'd1)
      $display("FAIL filter_stat got=%0d want=%0d", stat_filtered, before + 32'd1);
    else n_pass++;
`endif
  endtask

  task automatic test_random;
    frame_obs_t o, e;
    logic [47:0] src, dst;
    logic [2:0]  port;
    int s, d, bad;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      s = int'($urandom_range(0, 17));
      d = int'($urandom_range(0, 19));
      src = (s < 16) ? 48'h0200_0000_0010 + 48'(s) : (s == 16) ? 48'h0 : 48'h0300_0000_0001;
      dst = (d < 16) ? 48'h0200_0000_0010 + 48'(d) : (d == 16) ? 48'h0 :
            (d == 17) ? MAC_BC : (d == 18) ? 48'h0100_5E00_0001 : MAC_0A;
      port = 3'($urandom_range(0, 7));
      model_frame(dst, src, port, e);
      run_frame(dst, src, port, int'($urandom_range(0, 3)), o);
      n_checks++;
      if (o !== e) begin
        bad++;
        if (bad <= 5) $display("FAIL random_frame n=%0d got=%p want=%p", n, o, e);
      end else n_pass++;
    end
  endtask

  task automatic test_table_full;
    frame_obs_t o, e;
    int i;
    i = 0;
    while (mdl_tab.num() < TABLE_DEPTH && i < 40) begin
      model_frame(MAC_BC, 48'h0200_0000_0100 + 48'(i), 3'(i), e);
      run_frame(MAC_BC, 48'h0200_0000_0100 + 48'(i), 3'(i), 0, o);
      n_checks++;
      if (o !== e) $display("FAIL fill_frame i=%0d got=%p want=%p", i, o, e); else n_pass++;
      i++;
    end
    n_checks++;
    if (bus.table_full !== 1'b1) $display("FAIL table_full got=%b want=1", bus.table_full); else n_pass++;
    model_frame(MAC_0A, 48'h0200_0000_01FF, 3'd6, e);
    run_frame(MAC_0A, 48'h0200_0000_01FF, 3'd6, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL full_frame got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.nwr !== 4'd0 || o.mask !== 8'h08)
      $display("FAIL full_no_learn got nwr=%0d mask=%h want 0/08", o.nwr, o.mask);
    else n_pass++;
  endtask

  task automatic test_stats;
`ifdef MAC_FWD_STATS_EN
    n_checks++;
    if (stat_frames !== 32'(ex_frames) || stat_learns !== 32'(ex_learns) ||
        stat_floods !== 32'(ex_floods) || stat_filtered !== 32'(ex_filt))
      $display("FAIL stats got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
               stat_frames, stat_learns, stat_floods, stat_filtered, ex_frames, ex_learns, ex_floods, ex_filt);
    else n_pass++;
`endif
    n_checks++;
    if (viol !== 0) $display("FAIL strobe_protocol got=%0d violations want=0", viol); else n_pass++;
  endtask

  task automatic test_hold_and_reset;
    frame_obs_t o, e;
    logic [72:0] outs;
    model_frame(MAC_0B, MAC_0A, 3'd1, e);
    run_frame(MAC_0B, MAC_0A, 3'd1, 10, o);
    n_checks++;
    if (o !== e) $display("FAIL hold_frame got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.stable !== 1'b1 || o.mask !== 8'h20)
      $display("FAIL hold_stable got stable=%b mask=%h want 1/20", o.stable, o.mask);
    else n_pass++;
    // Second frame is aborted by reset while its destination lookup is outstanding.
    bus.hdr_valid        = 1'b1;
    bus.hdr_dst_mac      = MAC_0B;
    bus.hdr_src_mac      = MAC_0A;
    bus.hdr_ingress_port = 3'd1;
    @(posedge clk);
    @(negedge clk);
    bus.hdr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {bus.hdr_ready, bus.cam_write_enable, bus.cam_match_enable, bus.cam_key, bus.cam_index,
            bus.fwd_valid, bus.fwd_port_mask, bus.fwd_flood, bus.table_full};
    n_checks++;
    if (outs !== '0) $display("FAIL abort_outputs got=%h want=0", outs); else n_pass++;
    mdl_tab.delete();
`ifdef MAC_FWD_STATS_EN
    ex_frames = 0; ex_learns = 0; ex_floods = 0; ex_filt = 0;
`endif
    @(negedge clk);
    n_checks++;
    if (bus.hdr_ready !== 1'b0) $display("FAIL abort_ready_in_reset got=%b want=0", bus.hdr_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.hdr_ready !== 1'b1) $display("FAIL abort_ready_after got=%b want=1", bus.hdr_ready); else n_pass++;
  endtask

  task automatic test_after_reset;
    frame_obs_t o, e;
    model_frame(MAC_0B, MAC_0A, 3'd2, e);
    run_frame(MAC_0B, MAC_0A, 3'd2, 0, o);
    n_checks++;
    if (o !== e) $display("FAIL after_reset got=%p want=%p", o, e); else n_pass++;
    n_checks++;
    if (o.nwr !== 4'd1 || o.mask !== 8'hFB || bus.table_full !== 1'b0)
      $display("FAIL after_reset_fixed got nwr=%0d mask=%h full=%b want 1/FB/0", o.nwr, o.mask, bus.table_full);
    else n_pass++;
  endtask

  initial begin
    bus.hdr_valid        = 1'b0;
    bus.hdr_dst_mac      = '0;
    bus.hdr_src_mac      = '0;
    bus.hdr_ingress_port = '0;
    bus.fwd_ready        = 1'b0;
    @(negedge clk);
    test_reset();
    test_learn_flood();
    test_known_dst();
    test_broadcast();
    test_filter();
    test_random();
    test_table_full();
    test_stats();
    test_hold_and_reset();
    test_after_reset();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
